q_output_port: RTL and testbench

- Peripheral stage directly downstream of the CPU's Q (output) register.
- Captures each byte the CPU writes to Q into a small FIFO.
- Serialises the queued bytes onto a single asynchronous-serial line (8N1, LSB first).
- Lets a running program emit bytes without stalling, with overflow reported.

---
 rtl/q_output_port_if.sv | 41 ++++
 rtl/q_output_port.sv | 199 +++++++++++++++++++
 tb/tb_q_output_port.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/q_output_port_if.sv
// q_output_port_if
//   Bundles the CPU-facing strobe/data and the serial-side status lines of
//   the Q output port so that the port and its users share one connection.
//
//   Signals:
//     qWrite    CPU -> port   one-cycle strobe, Q register just loaded
//     qData     CPU -> port   Q register value, valid while qWrite=1
//     tx        port -> line  asynchronous serial output, idle high
//     busy      port -> CPU   FIFO non-empty or a frame in flight
//     full      port -> CPU   FIFO holds DEPTH entries
//     overflow  port -> CPU   sticky: a write was dropped since reset
//
//   Modports:
//     master  the CPU side (drives qWrite/qData, observes status)
//     slave   the port itself
interface q_output_port_if;
  logic       qWrite;
  logic [7:0] qData;
  logic       tx;
  logic       busy;
  logic       full;
  logic       overflow;

  modport master (
    output qWrite,
    output qData,
    input  tx,
    input  busy,
    input  full,
    input  overflow
  );

  modport slave (
    input  qWrite,
    input  qData,
    output tx,
    output busy,
    output full,
    output overflow
  );
endinterface

// File: rtl/q_output_port.sv
// q_output_port
//   Sits directly downstream of the CPU's Q register. Every byte the CPU
//   writes to Q is queued in a small FIFO and then sent out on a single
//   8N1 asynchronous serial line, LSB first, so a program can emit bytes
//   without stalling. Writes that arrive while the FIFO is full (and no
//   byte leaves on the same edge) are dropped and flagged by a sticky
//   overflow bit.
//
//   Parameters:
//     DIV    clk cycles per serial bit (1..255)
//     DEPTH  FIFO entries (power of two, 2..16)
//
//   Ports:
//     clk       system clock, all state changes on its rising edge
//     resetBar  synchronous active-low reset
//     bus       q_output_port_if.slave: qWrite/qData in,
//               tx/busy/full/overflow out
//
//   Frame timing: a byte popped at edge n drives the start bit right after
//   edge n; the frame occupies exactly 10*DIV cycles, followed by one IDLE
//   cycle before the next pop, giving a period of 10*DIV+1 cycles when the
//   FIFO stays non-empty.
module q_output_port #(
  parameter int DIV   = 4,
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              resetBar,
  q_output_port_if.slave    bus
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
  localparam logic [CW-1:0] ONE_COUNT  = CW'(1);
  localparam logic [AW-1:0] ONE_PTR    = AW'(1);
  localparam logic [7:0]    DIV_LAST   = 8'(DIV - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  logic [7:0]    mem [DEPTH];

  logic [AW-1:0] rd_ptr_reg, rd_ptr_next;
  logic [AW-1:0] wr_ptr_reg, wr_ptr_next;
  logic [CW-1:0] count_reg,  count_next;
  logic          overflow_reg, overflow_next;

  state_t        state_reg, state_next;
  logic [7:0]    div_reg,   div_next;
  logic [2:0]    bit_reg,   bit_next;
  logic [7:0]    shift_reg, shift_next;
  logic          tx_reg,    tx_next;

  // ---------------------------------------------------------------------
  // FIFO control
  // ---------------------------------------------------------------------
  logic pop;
  logic push;
  logic div_last;

  // A pop only happens from IDLE, which is what inserts the single idle
  // cycle between back-to-back frames.
  assign pop      = (state_reg == IDLE) && (count_reg != '0);
  // A full FIFO can still accept a byte on the very edge its head leaves.
  assign push     = bus.qWrite && ((count_reg != FULL_COUNT) || pop);
  assign div_last = (div_reg == DIV_LAST);

  always_comb begin
    rd_ptr_next   = rd_ptr_reg;
    wr_ptr_next   = wr_ptr_reg;
    count_next    = count_reg;
    overflow_next = overflow_reg;

    if (pop)  rd_ptr_next = rd_ptr_reg + ONE_PTR;
    if (push) wr_ptr_next = wr_ptr_reg + ONE_PTR;

    case ({push, pop})
      2'b10:   count_next = count_reg + ONE_COUNT;
      2'b01:   count_next = count_reg - ONE_COUNT;
      default: count_next = count_reg;
    endcase

    if (bus.qWrite && !push) overflow_next = 1'b1;
  end

  // ---------------------------------------------------------------------
  // Transmit FSM (next-state / datapath)
  // ---------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    div_next   = div_reg;
    bit_next   = bit_reg;
    shift_next = shift_reg;

    case (state_reg)
      IDLE: begin
        if (pop) begin
          shift_next = mem[rd_ptr_reg];
          div_next   = '0;
          state_next = START;
        end
      end

      START: begin
        if (div_last) begin
          div_next   = '0;
          bit_next   = '0;
          state_next = DATA;
        end else begin
          div_next = div_reg + 8'd1;
        end
      end

      DATA: begin
        if (div_last) begin
          div_next   = '0;
          shift_next = {1'b0, shift_reg[7:1]};
          bit_next   = bit_reg + 3'd1;
          if (bit_reg == 3'd7) state_next = STOP;
        end else begin
          div_next = div_reg + 8'd1;
        end
      end

      STOP: begin
        if (div_last) begin
          div_next   = '0;
          state_next = IDLE;
        end else begin
          div_next = div_reg + 8'd1;
        end
      end

      default: state_next = IDLE;
    endcase

    // The line level is decided from where the FSM will be after the edge
    // and registered, so tx changes exactly on clock edges with no glitch.
    // In DATA the bit on the line is always the LSB of the shift register.
    case (state_next)
      START:   tx_next = 1'b0;
      DATA:    tx_next = shift_next[0];
      default: tx_next = 1'b1;
    endcase
  end

  // ---------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!resetBar) begin
      rd_ptr_reg   <= '0;
      wr_ptr_reg   <= '0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
      state_reg    <= IDLE;
      div_reg      <= '0;
      bit_reg      <= '0;
      shift_reg    <= '0;
      tx_reg       <= 1'b1;
    end else begin
      rd_ptr_reg   <= rd_ptr_next;
      wr_ptr_reg   <= wr_ptr_next;
      count_reg    <= count_next;
      overflow_reg <= overflow_next;
      state_reg    <= state_next;
      div_reg      <= div_next;
      bit_reg      <= bit_next;
      shift_reg    <= shift_next;
      tx_reg       <= tx_next;
    end
  end

  // Storage needs no reset: an entry is only read after it was written.
  // When full with a simultaneous pop, wr_ptr equals rd_ptr; the head is
  // captured into the shift register from the pre-edge contents, so the
  // overwrite on the same edge is safe.
  always_ff @(posedge clk) begin
    if (resetBar && push) mem[wr_ptr_reg] <= bus.qData;
  end

  // ---------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------
  assign bus.tx       = tx_reg;
  assign bus.busy     = (state_reg != IDLE) || (count_reg != '0);
  assign bus.full     = (count_reg == FULL_COUNT);
  assign bus.overflow = overflow_reg;

endmodule

// File: tb/tb_q_output_port.sv
// tb_q_output_port
//   Directed bench for q_output_port (DIV=2, DEPTH=4). A queue-based model
//   of the port predicts tx/busy/full/overflow every cycle from frame age
//   arithmetic; a line receiver decodes tx back into bytes; literal
//   expectations pin waveform details and decoded byte sequences.
module tb_q_output_port;
  localparam int DIV   = 2;
  localparam int DEPTH = 4;

  logic clk      = 1'b0;
  logic resetBar = 1'b0;

  q_output_port_if bus ();

  q_output_port #(.DIV(DIV), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .resetBar (resetBar),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Model: queue of waiting bytes plus the byte on the line and its age
  // (edges since it was popped).
  logic [7:0] m_q [$];
  bit         m_active = 1'b0;
  int         m_age    = 0;
  logic [7:0] m_cur    = 8'h00;
  bit         m_ovf    = 1'b0;
  bit         m_valid  = 1'b0;

  // Line receiver
  logic [7:0] rx_q [$];
  bit         rx_active = 1'b0;
  int         rx_t      = 0;
  logic [7:0] rx_byte   = 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic model_tx();
    if (!m_active)       return 1'b1;
    if (m_age < DIV)     return 1'b0;
    if (m_age < 9 * DIV) return m_cur[m_age / DIV - 1];
    return 1'b1;
  endfunction

  always @(posedge clk) begin : model_blk
    bit pop;
    if (!resetBar) begin
      m_q.delete();
      m_active = 1'b0;
      m_age    = 0;
      m_ovf    = 1'b0;
      m_valid  = 1'b1;
    end else if (m_valid) begin
      pop = !m_active && (m_q.size() != 0);
      if (m_active) begin
        m_age++;
        if (m_age == 10 * DIV) m_active = 1'b0;
      end
      if (pop) begin
        m_cur    = m_q.pop_front();
        m_active = 1'b1;
        m_age    = 0;
      end
      if (bus.qWrite) begin
        if (m_q.size() < DEPTH) m_q.push_back(bus.qData);
        else                    m_ovf = 1'b1;
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (m_valid) begin
      check("tx",       bus.tx,       model_tx());
      check("busy",     bus.busy,     m_active || (m_q.size() != 0));
      check("full",     bus.full,     m_q.size() == DEPTH);
      check("overflow", bus.overflow, m_ovf);

      if (!resetBar) begin
        rx_active = 1'b0;
      end else if (!rx_active) begin
        if (bus.tx == 1'b0) begin
          rx_active = 1'b1;
          rx_t      = 0;
        end
      end else begin
        rx_t++;
        if (rx_t >= DIV && rx_t < 9 * DIV && (rx_t % DIV) == 0)
          rx_byte[rx_t / DIV - 1] = bus.tx;
        if (rx_t == 9 * DIV) begin
          check("stop_bit", bus.tx, 1);
          rx_q.push_back(rx_byte);
          rx_active = 1'b0;
        end
      end
    end
  end

  // One clock: inputs change on the falling edge, return 1 time unit
  // after the rising edge so registered outputs are settled.
  task automatic cycle(input logic rb, input logic w, input logic [7:0] d);
    @(negedge clk);
    resetBar   = rb;
    bus.qWrite = w;
    bus.qData  = d;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    cycle(1'b0, 1'b0, 8'h00);
    rx_q.delete();
  endtask

  task automatic drain();
    int n = 0;
    while ((bus.busy || m_active || m_q.size() != 0) && n < 1000) begin
      cycle(1'b1, 1'b0, 8'h00);
      n++;
    end
    check("drain_in_time", n < 1000, 1);
    repeat (3) cycle(1'b1, 1'b0, 8'h00);
  endtask

  task automatic check_rx(input string name, input logic [63:0] exp, input int n);
    check({name, "_count"}, rx_q.size(), n);
    for (int i = 0; i < n && i < rx_q.size(); i++)
      check({name, "_byte"}, rx_q[i], exp[8*i +: 8]);
  endtask

  initial begin : stim
    logic [19:0] wave_a5;
    bus.qWrite = 1'b0;
    bus.qData  = 8'h00;

    // Reset, then 50 idle cycles
    cycle(1'b0, 1'b0, 8'h00);
    do_reset();
    check("rst_tx",   bus.tx,       1);
    check("rst_busy", bus.busy,     0);
    check("rst_full", bus.full,     0);
    check("rst_ovf",  bus.overflow, 0);
    repeat (50) cycle(1'b1, 1'b0, 8'h00);
    check("idle_tx",   bus.tx,   1);
    check("idle_busy", bus.busy, 0);

    // Single byte 0xA5: start 0,0; bits 1,0,1,0,0,1,0,1; stop 1,1
    wave_a5 = 20'b1111_0011_0000_1100_1100;
    cycle(1'b1, 1'b1, 8'hA5);
    for (int i = 0; i < 20; i++) begin
      cycle(1'b1, 1'b0, 8'h00);
      check("a5_wave", bus.tx, wave_a5[i]);
      if (i == 0)  check("a5_busy_rise", bus.busy, 1);
      if (i == 19) check("a5_busy_stop", bus.busy, 1);
    end
    cycle(1'b1, 1'b0, 8'h00);
    check("a5_busy_fall", bus.busy, 0);
    check_rx("a5_rx", 64'hA5, 1);

    // Five back-to-back writes: all accepted, full afterwards
    do_reset();
    for (int b = 1; b <= 5; b++) cycle(1'b1, 1'b1, 8'(b));
    check("five_full", bus.full,     1);
    check("five_ovf",  bus.overflow, 0);
    drain();
    check("five_ovf_end", bus.overflow, 0);
    check_rx("five_rx", 64'h05_04_03_02_01, 5);

    // Six writes: the sixth is dropped, overflow is sticky
    do_reset();
    for (int b = 1; b <= 6; b++) cycle(1'b1, 1'b1, 8'(b));
    check("six_ovf",  bus.overflow, 1);
    check("six_full", bus.full,     1);
    drain();
    check("six_ovf_sticky", bus.overflow, 1);
    check_rx("six_rx", 64'h05_04_03_02_01, 5);

    // Write on the pop edge of a full FIFO
    do_reset();
    for (int b = 1; b <= 5; b++) cycle(1'b1, 1'b1, 8'(b));
    repeat (17) cycle(1'b1, 1'b0, 8'h00);
    check("pre_pop_full", bus.full, 1);
    cycle(1'b1, 1'b1, 8'h77);
    check("pop_write_full", bus.full,     1);
    check("pop_write_ovf",  bus.overflow, 0);
    drain();
    check_rx("pop_write_rx", 64'h77_05_04_03_02_01, 6);

    // Reset during DATA bit 3 of 0xFF with two bytes queued
    do_reset();
    cycle(1'b1, 1'b1, 8'hFF);
    cycle(1'b1, 1'b1, 8'h11);
    cycle(1'b1, 1'b1, 8'h22);
    repeat (7) cycle(1'b1, 1'b0, 8'h00);
    check("pre_rst_tx", bus.tx, 1);
    cycle(1'b0, 1'b0, 8'h00);
    check("mid_rst_tx",   bus.tx,   1);
    check("mid_rst_busy", bus.busy, 0);
    check("mid_rst_full", bus.full, 0);
    rx_q.delete();
    cycle(1'b1, 1'b1, 8'h3C);
    drain();
    check_rx("after_rst_rx", 64'h3C, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
